// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode/funct constants and W-stage decode enums
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_kind_e;
    typedef enum logic [1:0] {WD_ALU, WD_MEM, WD_PC8} wd_sel_e;
    typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_RA} dst_e;

endpackage

// File: rtl/pipeline_mw_if.sv
// rtl/pipeline_mw_if.sv - M-stage inputs and W-stage outputs of the M/W pipeline register
interface pipeline_mw_if;
    logic        En;
    logic        Clr;
    logic [31:0] Instr_M;
    logic [31:0] PCPlus4_M;
    logic [31:0] ALUOutput_M;
    logic [31:0] MemOut;
    logic [31:0] Instr_W;
    logic [31:0] PCPlus4_W;
    logic        RegWrite_W;
    logic [4:0]  A3_W;
    logic [31:0] RFWD_W;
    logic        Valid_W;
    logic [31:0] RetireCnt;

    modport master (
        output En, Clr, Instr_M, PCPlus4_M, ALUOutput_M, MemOut,
        input  Instr_W, PCPlus4_W, RegWrite_W, A3_W, RFWD_W, Valid_W, RetireCnt
    );

    modport slave (
        input  En, Clr, Instr_M, PCPlus4_M, ALUOutput_M, MemOut,
        output Instr_W, PCPlus4_W, RegWrite_W, A3_W, RFWD_W, Valid_W, RetireCnt
    );
endinterface

// File: rtl/pipeline_mw_load_ext.sv
// rtl/pipeline_mw_load_ext.sv - load data byte/halfword selection and extension
import mips_defs::*;

module load_ext (
    input  logic [31:0] word_i,
    input  logic [1:0]  a_i,
    input  ld_kind_e    kind_i,
    output logic [31:0] result_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (a_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        // a_i[0] is deliberately ignored for halfwords: misaligned lh/lhu is not trapped
        half_sel = a_i[1] ? word_i[31:16] : word_i[15:0];

        result_o = word_i;
        case (kind_i)
            LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result_o = {24'h000000, byte_sel};
            LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result_o = {16'h0000, half_sel};
            default: result_o = word_i;
        endcase
    end
endmodule

// File: rtl/pipeline_mw.sv
// rtl/pipeline_mw.sv - M/W pipeline register, writeback decode/select and retire counter
// Optional MW_TRACE_EN prints a register-write trace line on each committed write.
import mips_defs::*;

module pipeline_mw (
    input  logic          CLK,
    input  logic          Reset,
    pipeline_mw_if.slave  mw
);
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mem_q, mem_d;
    logic        valid_q, valid_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    dst_e        dst;
    wd_sel_e     wd_sel;
    ld_kind_e    ld_kind;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  a3;
    logic        reg_write;
    logic [31:0] ld_result;
    logic [31:0] rfwd;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        valid_d = valid_q;
        if (mw.Clr) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            alu_d   = 32'h0;
            mem_d   = 32'h0;
            valid_d = 1'b0;
        end else if (mw.En) begin
            instr_d = mw.Instr_M;
            pc4_d   = mw.PCPlus4_M;
            alu_d   = mw.ALUOutput_M;
            mem_d   = mw.MemOut;
            valid_d = 1'b1;
        end
        // Counts the instruction currently in W, independent of En/Clr this edge
        retire_cnt_d = valid_q ? retire_cnt_q + 32'd1 : retire_cnt_q;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            alu_q        <= 32'h0;
            mem_q        <= 32'h0;
            valid_q      <= 1'b0;
            retire_cnt_q <= 32'h0;
        end else begin
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            alu_q        <= alu_d;
            mem_q        <= mem_d;
            valid_q      <= valid_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign op = instr_q[31:26];
    assign fn = instr_q[5:0];

    always_comb begin
        dst     = DST_NONE;
        wd_sel  = WD_ALU;
        ld_kind = LD_W;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_ADDU, F_SUBU, F_AND, F_OR, F_NOR, F_XOR, F_SLT, F_SLTU,
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO:
                        dst = DST_RD;
                    F_JALR: begin
                        dst    = DST_RD;
                        wd_sel = WD_PC8;
                    end
                    F_JR, F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU:
                        dst = DST_NONE;
                    default: dst = DST_NONE;
                endcase
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU:
                dst = DST_RT;
            OP_LW:  begin dst = DST_RT; wd_sel = WD_MEM; ld_kind = LD_W;  end
            OP_LB:  begin dst = DST_RT; wd_sel = WD_MEM; ld_kind = LD_B;  end
            OP_LBU: begin dst = DST_RT; wd_sel = WD_MEM; ld_kind = LD_BU; end
            OP_LH:  begin dst = DST_RT; wd_sel = WD_MEM; ld_kind = LD_H;  end
            OP_LHU: begin dst = DST_RT; wd_sel = WD_MEM; ld_kind = LD_HU; end
            OP_JAL: begin dst = DST_RA; wd_sel = WD_PC8; end
            OP_J, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW:
                dst = DST_NONE;
            default: dst = DST_NONE;
        endcase
    end

    always_comb begin
        a3 = 5'd0;
        case (dst)
            DST_RD:  a3 = instr_q[15:11];
            DST_RT:  a3 = instr_q[20:16];
            DST_RA:  a3 = 5'd31;
            default: a3 = 5'd0;
        endcase
    end

    assign reg_write = (dst != DST_NONE) && (a3 != 5'd0) && valid_q;

    load_ext u_load_ext (
        .word_i   (mem_q),
        .a_i      (alu_q[1:0]),
        .kind_i   (ld_kind),
        .result_o (ld_result)
    );

    always_comb begin
        rfwd = alu_q;
        case (wd_sel)
            WD_MEM:  rfwd = ld_result;
            WD_PC8:  rfwd = pc4_q + 32'd4;
            default: rfwd = alu_q;
        endcase
    end

    assign mw.Instr_W    = instr_q;
    assign mw.PCPlus4_W  = pc4_q;
    assign mw.RegWrite_W = reg_write;
    assign mw.A3_W       = a3;
    assign mw.RFWD_W     = rfwd;
    assign mw.Valid_W    = valid_q;
    assign mw.RetireCnt  = retire_cnt_q;

`ifdef MW_TRACE_EN
    always @(posedge CLK) begin
        if (Reset && mw.En && reg_write)
            $display("%d@%h: $%02d <= %h", $time, pc4_q - 32'd4, a3, rfwd);
    end
`endif

endmodule

// File: tb/tb_pipeline_mw.sv
// tb/tb_pipeline_mw.sv - scoreboarded random and directed bench for pipeline_mw
module tb_pipeline_mw;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    pipeline_mw_if mw();
    pipeline_mw dut (.CLK(CLK), .Reset(Reset), .mw(mw));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        rw;
        logic [4:0]  a3;
        logic [31:0] rfwd;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] m_instr, m_pc4, m_alu, m_mem, m_cnt;
    logic        m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t        e;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [7:0]  b;
        logic [15:0] h;
        op   = m_instr[31:26];
        fn   = m_instr[5:0];
        dst  = 5'd0;
        data = m_alu;
        b    = 8'(m_mem >> (8 * m_alu[1:0]));
        h    = m_alu[1] ? m_mem[31:16] : m_mem[15:0];
        if (op == 6'h00) begin
            if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                           6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h09})
                dst = m_instr[15:11];
            if (fn == 6'h09) data = m_pc4 + 32'd4;
        end else if (op inside {6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f}) begin
            dst = m_instr[20:16];
        end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            dst = m_instr[20:16];
            case (op)
                6'h20:   data = 32'($signed(b));
                6'h24:   data = 32'(b);
                6'h21:   data = 32'($signed(h));
                6'h25:   data = 32'(h);
                default: data = m_mem;
            endcase
        end else if (op == 6'h03) begin
            dst  = 5'd31;
            data = m_pc4 + 32'd4;
        end
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.a3    = dst;
        e.rw    = m_valid && (dst != 5'd0);
        e.rfwd  = data;
        e.valid = m_valid;
        e.cnt   = m_cnt;
        return e;
    endfunction

    task automatic model_reset();
        m_instr = 0; m_pc4 = 0; m_alu = 0; m_mem = 0; m_cnt = 0; m_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic step(input logic en, input logic clr, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] mem);
        mw.En = en; mw.Clr = clr; mw.Instr_M = instr;
        mw.PCPlus4_M = pc4; mw.ALUOutput_M = alu; mw.MemOut = mem;
        @(posedge CLK);
        if (m_valid) m_cnt = m_cnt + 32'd1;
        if (clr) begin
            m_instr = 0; m_pc4 = 0; m_alu = 0; m_mem = 0; m_valid = 1'b0;
        end else if (en) begin
            m_instr = instr; m_pc4 = pc4; m_alu = alu; m_mem = mem; m_valid = 1'b1;
        end
        #1 q.push_back(model_out());
        @(negedge CLK);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("Instr_W",    mw.Instr_W,           e.instr);
                check("PCPlus4_W",  mw.PCPlus4_W,         e.pc4);
                check("RegWrite_W", 32'(mw.RegWrite_W),   32'(e.rw));
                check("A3_W",       32'(mw.A3_W),         32'(e.a3));
                check("RFWD_W",     mw.RFWD_W,            e.rfwd);
                check("Valid_W",    32'(mw.Valid_W),      32'(e.valid));
                check("RetireCnt",  mw.RetireCnt,         e.cnt);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_Instr_W"},    mw.Instr_W,          32'h0);
        check({tag, "_PCPlus4_W"},  mw.PCPlus4_W,        32'h0);
        check({tag, "_RegWrite_W"}, 32'(mw.RegWrite_W),  32'h0);
        check({tag, "_A3_W"},       32'(mw.A3_W),        32'h0);
        check({tag, "_RFWD_W"},     mw.RFWD_W,           32'h0);
        check({tag, "_Valid_W"},    32'(mw.Valid_W),     32'h0);
        check({tag, "_RetireCnt"},  mw.RetireCnt,        32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h00, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                                 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h03,
                                 6'h04, 6'h2b, 6'h28, 6'h02};
        logic [5:0] fns [24] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                                 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                                 6'h09, 6'h08, 6'h11, 6'h13, 6'h18, 6'h1a, 6'h20, 6'h3f};
        logic [5:0] op, fn;
        op = ($urandom_range(15) == 0) ? 6'($urandom) : ops[$urandom_range(19)];
        fn = fns[$urandom_range(23)];
        return {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn};
    endfunction

    localparam logic [31:0] MEMW = 32'h80F17F01;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        Reset = 1'b0;
        mw.En = 1'b0; mw.Clr = 1'b0; mw.Instr_M = 0; mw.PCPlus4_M = 0;
        mw.ALUOutput_M = 0; mw.MemOut = 0;

        repeat (4) begin
            @(negedge CLK);
            mw.En = 1'b1; mw.Clr = 1'($urandom); mw.Instr_M = $urandom;
            mw.PCPlus4_M = $urandom; mw.ALUOutput_M = $urandom; mw.MemOut = $urandom;
            @(posedge CLK);
            #2 check_all_zero("in_reset");
        end
        @(negedge CLK);
        Reset = 1'b1;

        // addu $3,$1,$2
        step(1, 0, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h0000_1004, 32'h5, $urandom);
        check("addu_A3", 32'(mw.A3_W), 32'd3);
        check("addu_RFWD", mw.RFWD_W, 32'h5);
        check("addu_RegWrite", 32'(mw.RegWrite_W), 32'd1);
        check("addu_cnt0", mw.RetireCnt, 32'd0);

        step(1, 0, {6'h20, 5'd0, 5'd5, 16'h0}, 32'h1008, 32'h101, MEMW);
        check("addu_cnt1", mw.RetireCnt, 32'd1);
        check("lb_a1", mw.RFWD_W, 32'h0000007F);
        step(1, 0, {6'h20, 5'd0, 5'd5, 16'h0}, 32'h100C, 32'h103, MEMW);
        check("lb_a3", mw.RFWD_W, 32'hFFFFFF80);
        step(1, 0, {6'h24, 5'd0, 5'd5, 16'h0}, 32'h1010, 32'h103, MEMW);
        check("lbu_a3", mw.RFWD_W, 32'h00000080);
        step(1, 0, {6'h21, 5'd0, 5'd5, 16'h0}, 32'h1014, 32'h102, MEMW);
        check("lh_a2", mw.RFWD_W, 32'hFFFF80F1);
        step(1, 0, {6'h25, 5'd0, 5'd5, 16'h0}, 32'h1018, 32'h103, MEMW);
        check("lhu_a3", mw.RFWD_W, 32'h000080F1);
        step(1, 0, {6'h23, 5'd0, 5'd5, 16'h0}, 32'h101C, 32'h100, MEMW);
        check("lw", mw.RFWD_W, 32'h80F17F01);

        step(1, 0, {6'h03, 26'h0}, 32'h00003004, $urandom, $urandom);
        check("jal_A3", 32'(mw.A3_W), 32'd31);
        check("jal_RFWD", mw.RFWD_W, 32'h00003008);
        step(1, 0, {6'h09, 5'd1, 5'd0, 16'h7}, 32'h3008, 32'h7, $urandom);
        check("addiu_rt0_RegWrite", 32'(mw.RegWrite_W), 32'd0);
        step(1, 0, {6'h2b, 5'd1, 5'd5, 16'h4}, 32'h300C, 32'h4, $urandom);
        check("sw_RegWrite", 32'(mw.RegWrite_W), 32'd0);

        step(1, 0, {6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h25}, 32'h3010, 32'hABCD, 0);
        repeat (3) step(0, 0, $urandom, $urandom, $urandom, $urandom);
        check("hold_A3", 32'(mw.A3_W), 32'd9);
        check("hold_RFWD", mw.RFWD_W, 32'hABCD);

        step(1, 1, $urandom, $urandom, $urandom, $urandom);
        check("clr_Valid", 32'(mw.Valid_W), 32'd0);
        check("clr_Instr", mw.Instr_W, 32'd0);
        step(0, 0, $urandom, $urandom, $urandom, $urandom);
        step(1, 0, {6'h0d, 5'd0, 5'd4, 16'h1}, 32'h4004, 32'h1, 0);

        force dut.retire_cnt_q = 32'hFFFFFFFE;
        m_cnt = 32'hFFFFFFFE;
        #1 release dut.retire_cnt_q;
        step(1, 0, {6'h0d, 5'd0, 5'd4, 16'h2}, 32'h4008, 32'h2, 0);
        step(1, 0, {6'h0d, 5'd0, 5'd4, 16'h3}, 32'h400C, 32'h3, 0);
        check("wrap_cnt", mw.RetireCnt, 32'h0);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                #2 Reset = 1'b0;
                #1 check_all_zero("async_reset");
                model_reset();
                @(negedge CLK);
                Reset = 1'b1;
            end
            step(($urandom_range(9) != 0), ($urandom_range(12) == 0), rand_instr(),
                 $urandom, $urandom, $urandom);
        end

        @(posedge CLK);
        #3;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
